// File: rtl/adpll_pkg.sv
// adpll_pkg
// Shared constants and types for the ADPLL TX symbol sequencer.
//   - ADPLL mode encodings (PD/TEST/RX/TX)
//   - register bus addresses of the sequencer
//   - tx_state_t: sequencer state (IDLE, ARMED, RUN)
package adpll_pkg;

  localparam logic [1:0] MODE_PD   = 2'd0;
  localparam logic [1:0] MODE_TEST = 2'd1;
  localparam logic [1:0] MODE_RX   = 2'd2;
  localparam logic [1:0] MODE_TX   = 2'd3;

  localparam logic [4:0] ADDR_CTRL     = 5'd0;
  localparam logic [4:0] ADDR_PERIOD   = 5'd1;
  localparam logic [4:0] ADDR_DATA     = 5'd2;
  localparam logic [4:0] ADDR_IDLE_SYM = 5'd3;
  localparam logic [4:0] ADDR_CLR      = 5'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/adpll_tx_sym_gen_if.sv
// adpll_tx_sym_gen_if
// CPU register bus used to program the TX symbol sequencer.
//   sel      : access select (one cycle per access)
//   write    : write strobe, qualified by sel
//   address  : register address
//   data_in  : write data
//   ready    : registered access-complete pulse from the slave
// Modports: master (CPU side), slave (sequencer side).
interface adpll_tx_sym_gen_if;
  logic        sel;
  logic        write;
  logic [4:0]  address;
  logic [31:0] data_in;
  logic        ready;

  modport master (output sel, output write, output address, output data_in, input ready);
  modport slave  (input sel, input write, input address, input data_in, output ready);
endinterface

// File: rtl/adpll_sym_fifo.sv
// adpll_sym_fifo
// Synchronous symbol FIFO with registered full/empty flags.
//   clk, rst : clock, asynchronous active-low reset (empties the FIFO)
//   push     : write din; dropped when full unless a pop happens the same cycle
//   pop      : advance read pointer; ignored when empty (no bypass)
//   flush    : empty the FIFO; overrides a same-cycle push/pop
//   din      : write data (WIDTH bits)
//   dout     : head-of-FIFO data (valid when !empty)
//   full     : DEPTH entries stored
//   empty    : no entries stored
module adpll_sym_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign dout      = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/adpll_tx_sym_gen.sv
// adpll_tx_sym_gen
// TX symbol sequencer: CPU-loaded symbol FIFO played out on data_mod at a
// programmable symbol period once the ADPLL is locked in TX mode.
// Optional feature macro: ADPLL_TX_PRBS_EN (PRBS9 symbol source, CTRL bit3).
//   clk          : reference clock
//   rst          : asynchronous active-low reset
//   en           : block enable (low forces IDLE)
//   adpll_mode   : PD/TEST/RX/TX mode of the loop
//   channel_lock : lock flag from adpll_ctr
//   bus          : CPU register bus (slave modport)
//   data_mod     : current symbol
//   sym_strobe   : one-cycle pulse per new symbol
//   fifo_full    : FIFO full flag
//   fifo_empty   : FIFO empty flag
//   underrun     : sticky, symbol needed while FIFO empty
//   overflow     : sticky, DATA write while full
//   running      : high in RUN
module adpll_tx_sym_gen
  import adpll_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SYM_BITS = 1,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          adpll_mode,
  input  logic                channel_lock,
  adpll_tx_sym_gen_if.slave   bus,
  output logic [SYM_BITS-1:0] data_mod,
  output logic                sym_strobe,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                underrun,
  output logic                overflow,
  output logic                running
);

  tx_state_t           state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    period;
  logic [SYM_BITS-1:0] idle_sym;
  logic [SYM_BITS-1:0] fifo_dout;
  logic [SYM_BITS-1:0] next_sym;
  logic                ready_r;
  logic                acc, wr_ctrl;
  logic                start_req, stop_req, flush_req, push_req;
  logic                clr_und, clr_ovf;
  logic                lock_ok, exit_run, exit_arm;
  logic                pop_slot, fifo_pop, starve, ovf_set;
  logic                unused_bits;

  assign unused_bits = ^bus.data_in;

  assign acc       = bus.sel && bus.write;
  assign wr_ctrl   = acc && (bus.address == ADDR_CTRL);
  // STOP in the same access as START cancels the START.
  assign start_req = wr_ctrl && bus.data_in[0] && !bus.data_in[1];
  assign stop_req  = wr_ctrl && bus.data_in[1];
  assign flush_req = wr_ctrl && bus.data_in[2];
  assign push_req  = acc && (bus.address == ADDR_DATA);
  assign clr_und   = acc && (bus.address == ADDR_CLR) && bus.data_in[0];
  assign clr_ovf   = acc && (bus.address == ADDR_CLR) && bus.data_in[1];

  assign lock_ok  = channel_lock && (adpll_mode == MODE_TX) && en;
  assign exit_run = stop_req || !lock_ok;
  assign exit_arm = stop_req || !en;
  assign pop_slot = (state == RUN) && !exit_run && (cnt == '0);

`ifdef ADPLL_TX_PRBS_EN
  logic       prbs_sel;
  logic [8:0] prbs;

  assign fifo_pop = pop_slot && !prbs_sel;
  assign next_sym = prbs_sel ? prbs[SYM_BITS-1:0] : (fifo_empty ? idle_sym : fifo_dout);

  // PRBS9 x^9+x^5+1, right-shifting so the seed bits come out first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prbs_sel <= 1'b0;
      prbs     <= 9'h1FF;
    end else begin
      if (wr_ctrl) prbs_sel <= bus.data_in[3];
      if (start_req && en)          prbs <= 9'h1FF;
      else if (pop_slot && prbs_sel) prbs <= {prbs[0] ^ prbs[4], prbs[8:1]};
    end
  end
`else
  assign fifo_pop = pop_slot;
  assign next_sym = fifo_empty ? idle_sym : fifo_dout;
`endif

  assign starve  = fifo_pop && fifo_empty;
  assign ovf_set = push_req && fifo_full && !(fifo_pop && !fifo_empty);

  adpll_sym_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SYM_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .flush (flush_req),
    .din   (bus.data_in[SYM_BITS-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.ready = ready_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r  <= 1'b0;
      period   <= CNT_W'(31);
      idle_sym <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ready_r <= bus.sel;
      if (acc && (bus.address == ADDR_PERIOD))   period   <= bus.data_in[CNT_W-1:0];
      if (acc && (bus.address == ADDR_IDLE_SYM)) idle_sym <= bus.data_in[SYM_BITS-1:0];
      // A set wins over a same-cycle clear.
      if (starve)       underrun <= 1'b1;
      else if (clr_und) underrun <= 1'b0;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Sequencer: entering RUN loads cnt=0 so the first pop lands one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      data_mod   <= '0;
      sym_strobe <= 1'b0;
      running    <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      case (state)
        IDLE: begin
          data_mod <= idle_sym;
          if (start_req && en) state <= ARMED;
        end
        ARMED: begin
          data_mod <= idle_sym;
          if (exit_arm) begin
            state <= IDLE;
          end else if (lock_ok) begin
            state   <= RUN;
            running <= 1'b1;
            cnt     <= '0;
          end
        end
        RUN: begin
          if (exit_run) begin
            state    <= IDLE;
            running  <= 1'b0;
            data_mod <= idle_sym;
          end else if (cnt == '0) begin
            data_mod   <= next_sym;
            sym_strobe <= 1'b1;
            cnt        <= period;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/adpll_tx_sym_gen.md
# adpll_tx_sym_gen

Parametrised TX symbol sequencer for the ADPLL. A CPU loads modulation symbols into a FIFO through the existing register bus. Once the loop reports channel lock in TX mode, the block plays the symbols out on `data_mod` at a programmable symbol period, and `adpll_ctr` consumes `data_mod`. It generalises the fixed 1-bit, 32-cycle random modulation into a buffered, multi-bit, rate-programmable source with underrun/overflow reporting.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `SYM_BITS`, 1: bits per symbol, 1..4 (2-FSK to 16-FSK).
- `CNT_W`, 8: width of the symbol-period counter.
- `clk` in 1: 32 MHz reference clock.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: block enable; low forces IDLE.
- `adpll_mode` in 2: PD=0, TEST=1, RX=2, TX=3.
- `channel_lock` in 1: lock flag from `adpll_ctr`.
- `sel` in 1: CPU select.
- `write` in 1: CPU write strobe; qualified by `sel`.
- `address` in 5: register address.
- `data_in` in 32: write data.
- `ready` out 1: access-complete pulse.
- `data_mod` out SYM_BITS: current symbol to the ADPLL.
- `sym_strobe` out 1: one-cycle pulse on each new symbol.
- `fifo_full` out 1: FIFO full flag.
- `fifo_empty` out 1: FIFO empty flag.
- `underrun` out 1: sticky flag; symbol needed while FIFO empty.
- `overflow` out 1: sticky flag; DATA write while full.
- `running` out 1: high in RUN state.

## Operation
- Registers (write-only), all acted on when `sel && write`:
  - 0 CTRL: bit0 START, bit1 STOP, bit2 FLUSH, bit3 PRBS_SEL (macro only).
  - 1 PERIOD[CNT_W-1:0]: cycles per symbol minus 1. Reset value 31 (1 Msym/s).
  - 2 DATA[SYM_BITS-1:0]: push to FIFO.
  - 3 IDLE_SYM[SYM_BITS-1:0]: symbol output when not running or on underrun. Reset value 0.
  - 4 CLR: bit0 clears `underrun`, bit1 clears `overflow`.
  - Other addresses: ignored.
- States:
  - IDLE: `data_mod`=IDLE_SYM. Goes to ARMED on START while `en`=1.
  - ARMED: goes to RUN when `channel_lock && adpll_mode==3 && en`.
  - RUN: symbol counter counts PERIOD..0. On entry and at each count 0, pop the FIFO, drive the popped value, pulse `sym_strobe`, reload PERIOD. If the FIFO is empty at a pop, drive IDLE_SYM and set `underrun`; `sym_strobe` still pulses.
- Exit conditions:
  - RUN→IDLE on STOP, `en`=0, loss of `channel_lock`, or mode≠3. ARMED→IDLE on STOP or `en`=0. Exit takes effect the next cycle; `data_mod` returns to IDLE_SYM.
  - STOP and START written in the same access: STOP wins.
- FIFO access:
  - Push when full: dropped, `overflow` set.
  - Push and pop in the same cycle when full: both succeed.
  - Push and pop in the same cycle when empty: the pop underruns and the push is stored; there is no bypass.
  - FLUSH empties the FIFO and overrides a same-cycle push. It does not change state.
- Sticky flags: a set and a CLR in the same cycle leave the flag set.
- PERIOD writes during RUN take effect at the next reload.

## Timing
- Reset values: `ready`=0, `data_mod`=0, `sym_strobe`=0, `fifo_full`=0, `fifo_empty`=1, `underrun`=0, `overflow`=0, `running`=0. State IDLE, PERIOD=31, IDLE_SYM=0.
- `ready` is a registered pulse one cycle after any `sel` cycle, reads and ignored addresses included.
- ARMED→RUN:
  - Lock qualifier true at edge N: `running`=1 after edge N.
  - First pop, `data_mod` and `sym_strobe` update at edge N+1.
  - Subsequent symbols follow every PERIOD+1 cycles.
- Flags `fifo_full`/`fifo_empty` are registered and update on the edge after the push/pop.
- Reset asserted mid-RUN: all outputs clear asynchronously and the FIFO empties.

## Configuration
- `ADPLL_TX_PRBS_EN` defined:
  - Adds a PRBS9 generator (x^9+x^5+1, seed 9'h1FF); its low SYM_BITS bits form each symbol.
  - CTRL bit3=1 selects PRBS instead of FIFO as the RUN source. `underrun` never sets in this mode.
  - The generator advances only on `sym_strobe`.
- Undefined: no PRBS logic is compiled and CTRL bit3 is ignored.

## Structure
- `adpll_pkg` holds:
  - the mode constants PD/TEST/RX/TX;
  - the register address constants;
  - the state typedef `tx_state_t` {IDLE, ARMED, RUN}.
- Sub-module `adpll_sym_fifo`: synchronous FIFO with DEPTH/WIDTH parameters, push/pop/flush and full/empty outputs.

## Test plan
- Reset, START, then lock in TX mode with no DATA written and PERIOD=31 → first `sym_strobe` 1 cycle after `running`, then every 32 cycles. `data_mod`=0 and `underrun`=1.
- SYM_BITS=2, push 3,1,2; START; lock in TX → `data_mod` sequence 3,1,2, then IDLE_SYM. `underrun` sets on the 4th strobe.
- DEPTH=16: push 17 times → `fifo_full`=1 after the 16th push, `overflow`=1 after the 17th. CLR=2 clears `overflow`.
- Deassert `channel_lock` mid-RUN → `running`=0 next cycle and `data_mod`=IDLE_SYM. Unread FIFO entries are retained.
- PERIOD=3 written during RUN with PERIOD=31 → current symbol lasts 32 cycles, later symbols 4 cycles.
- With `ADPLL_TX_PRBS_EN`, SYM_BITS=1, CTRL=0x9 → first 9 symbols all 1, matching the seed.
